dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: CPU load/store unit (port cpu_*) and debug/loader port (port dbg_*).
- Round-robin arbitration, request/ready handshake, WAIT_CYCLES configurable access stretch, misalignment rejection.
- Sits between the multi-cycle control unit and the data memory; drives its DMWr/MemRead/MemOp/MemEXT/address/din and samples its dout.

---
 rtl/dmem_arbiter_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arbiter_rr_arb2.sv | 22 ++
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: memory-op encodings, arbiter state encodings and alignment rule
package dmem_arbiter_pkg;

    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_BYTE = 2'b10;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Bytes are always aligned; halves need addr[0]=0, words need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] a);
        return (op == MEM_HALF && a[0]) || (op == MEM_WORD && a != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, debug and data-memory signals shared by the arbiter and its environment
interface dmem_arbiter_if;

    logic        cpu_req, cpu_we, cpu_ext, cpu_ready, cpu_err;
    logic [1:0]  cpu_op;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;

    logic        dbg_req, dbg_we, dbg_ext, dbg_ready, dbg_err;
    logic [1:0]  dbg_op;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;

    logic        mem_wr, mem_rd, mem_ext;
    logic [1:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_op, cpu_ext, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_err,
        input  dbg_req, dbg_we, dbg_op, dbg_ext, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ready, dbg_err,
        output mem_wr, mem_rd, mem_op, mem_ext, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_op, cpu_ext, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_err,
        output dbg_req, dbg_we, dbg_op, dbg_ext, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ready, dbg_err,
        input  mem_wr, mem_rd, mem_op, mem_ext, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; bit 0 is the CPU, bit 1 the debug port
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    output logic [1:0] o_grant
);

    logic r_last;

    assign o_grant[0] = i_req[0] & (~i_req[1] | r_last);
    assign o_grant[1] = i_req[1] & (~i_req[0] | ~r_last);

    // Remember the winner so a tie next time goes to the other port; CPU wins the first tie.
    always_ff @(posedge clk or posedge rst)
        if (rst) r_last <= GNT_DBG;
        else if (i_upd && |i_req) r_last <= o_grant[1];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU and the debug/loader port
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    arb_state_t       r_state, w_state;
    logic [1:0]       w_req, w_grant, w_op, r_op;
    logic             w_gid, w_we, w_ext, w_mis, w_start, w_last, w_resp;
    logic             r_gid, r_we, r_ext, r_err;
    logic [31:0]      w_addr, w_wdata, r_addr, r_wdata, r_cpu_rdata, r_dbg_rdata;
    logic [CNT_W-1:0] r_cnt;

    assign w_req   = {bus.dbg_req, bus.cpu_req};
    assign w_gid   = w_grant[1];
    assign w_we    = w_gid ? bus.dbg_we    : bus.cpu_we;
    assign w_op    = w_gid ? bus.dbg_op    : bus.cpu_op;
    assign w_ext   = w_gid ? bus.dbg_ext   : bus.cpu_ext;
    assign w_addr  = w_gid ? bus.dbg_addr  : bus.cpu_addr;
    assign w_wdata = w_gid ? bus.dbg_wdata : bus.cpu_wdata;
    assign w_mis   = is_misaligned(w_op, w_addr[1:0]);
    assign w_start = r_state == ARB_IDLE && |w_grant;
    assign w_last  = r_cnt == '0;
    assign w_resp  = r_state == ARB_RESP;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_req),
        .i_upd   (r_state == ARB_IDLE),
        .o_grant (w_grant)
    );

    // State register.
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= ARB_IDLE;
        else r_state <= w_state;

    // Next state: misaligned requests skip the memory cycle and answer at once.
    always_comb begin
        w_state = r_state;
        case (r_state)
            ARB_IDLE:   if (|w_grant) w_state = w_mis ? ARB_RESP : ARB_ACCESS;
            ARB_ACCESS: if (w_last) w_state = ARB_RESP;
            default:    w_state = ARB_IDLE;
        endcase
    end

    // Latch the granted request so memory signals stay stable for the whole access.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_gid   <= GNT_CPU;
            r_we    <= 1'b0;
            r_op    <= MEM_WORD;
            r_ext   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_gid   <= w_gid;
            r_we    <= w_we;
            r_op    <= w_op;
            r_ext   <= w_ext;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_err   <= w_mis;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
        end else if (r_state == ARB_ACCESS && !w_last) r_cnt <= r_cnt - CNT_W'(1);

    // Capture load data for the granted port on the final access cycle; stores return zero.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else if (r_state == ARB_ACCESS && w_last) begin
            if (r_gid == GNT_DBG) r_dbg_rdata <= r_we ? '0 : bus.mem_rdata;
            else r_cpu_rdata <= r_we ? '0 : bus.mem_rdata;
        end

    assign bus.mem_wr    = r_state == ARB_ACCESS && r_we && w_last;
    assign bus.mem_rd    = r_state == ARB_ACCESS && !r_we;
    assign bus.mem_op    = r_op;
    assign bus.mem_ext   = r_ext;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.cpu_ready = w_resp && r_gid == GNT_CPU;
    assign bus.cpu_err   = bus.cpu_ready && r_err;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dbg_ready = w_resp && r_gid == GNT_DBG;
    assign bus.dbg_err   = bus.dbg_ready && r_err;
    assign bus.dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a memory shadow model
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int          W         = 3;
    localparam logic [31:0] DATA_BASE = 32'h0000_1000;
    localparam logic [31:0] W0_XOR    = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0, n_fail = 0, n_wr = 0, n_wr0 = 0;
    int   order[$];
    logic [31:0] mem[64];
    logic [31:0] shadow[64];

    always #5 clk = ~clk;

    dmem_arbiter_if bus();
    dmem_arbiter_if bus0();

    dmem_arbiter #(.WAIT_CYCLES(W), .CNT_W(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    dmem_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Little-endian load of a byte/half/word out of a stored word, with optional sign extension.
    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] ofs,
                                        input logic [1:0] op, input logic ext);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{ofs, 3'b000} +: 8];
        h = w[{ofs[1], 4'b0000} +: 16];
        if (op == MEM_BYTE) return ext ? {{24{b[7]}}, b} : {24'b0, b};
        if (op == MEM_HALF) return ext ? {{16{h[15]}}, h} : {16'b0, h};
        return w;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] ofs, input logic [1:0] op);
        logic [31:0] r;
        r = old;
        if (op == MEM_BYTE) r[{ofs, 3'b000} +: 8] = wd[7:0];
        else if (op == MEM_HALF) r[{ofs[1], 4'b0000} +: 16] = wd[15:0];
        else r = wd;
        return r;
    endfunction

    assign bus.mem_rdata  = fmt(mem[bus.mem_addr[7:2]], bus.mem_addr[1:0], bus.mem_op, bus.mem_ext);
    assign bus0.mem_rdata = bus0.mem_addr ^ W0_XOR;

    always @(negedge clk) begin
        if (bus.mem_wr) begin
            mem[bus.mem_addr[7:2]] <= merge(mem[bus.mem_addr[7:2]], bus.mem_wdata, bus.mem_addr[1:0], bus.mem_op);
            n_wr++;
        end
        if (bus0.mem_wr) n_wr0++;
        if (bus.cpu_ready | bus.dbg_ready) chk("ready_overlap", {31'b0, bus.cpu_ready & bus.dbg_ready}, 0);
    end

    task automatic drive(input bit p, input bit r, input bit we, input logic [1:0] op,
                         input bit ext, input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            bus.dbg_req = r; bus.dbg_we = we; bus.dbg_op = op; bus.dbg_ext = ext; bus.dbg_addr = a; bus.dbg_wdata = wd;
        end else begin
            bus.cpu_req = r; bus.cpu_we = we; bus.cpu_op = op; bus.cpu_ext = ext; bus.cpu_addr = a; bus.cpu_wdata = wd;
        end
    endtask

    // One complete transaction on port p; called right after a clock edge.
    task automatic xact(input bit p, input bit we, input logic [1:0] op, input bit ext,
                        input logic [31:0] a, input logic [31:0] wd, input bit solo,
                        output logic [31:0] rd, output logic err);
        bit mis, got;
        int lat, nrd, bad, wr0;
        mis = (op == MEM_HALF && a[0]) || (op == MEM_WORD && a[1:0] != 2'b00);
        got = 0; lat = 0; nrd = 0; bad = 0; wr0 = n_wr; rd = '0; err = 1'b0;
        drive(p, 1, we, op, ext, a, wd);
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            if (solo && bus.mem_rd) begin
                nrd++;
                if (bus.mem_addr !== a) bad++;
            end
            if (p ? bus.dbg_ready : bus.cpu_ready) begin
                got = 1; lat = i;
                rd  = p ? bus.dbg_rdata : bus.cpu_rdata;
                err = p ? bus.dbg_err : bus.cpu_err;
            end
        end
        chk("ready_timeout", {31'b0, got}, 1);
        if (got) begin
            chk("err", {31'b0, err}, {31'b0, mis});
            if (!mis && !we) chk("rdata", rd, fmt(shadow[a[7:2]], a[1:0], op, ext));
            if (!mis && we) shadow[a[7:2]] = merge(shadow[a[7:2]], wd, a[1:0], op);
            if (solo) begin
                chk("latency", lat, mis ? 0 : W + 1);
                chk("rd_cycles", nrd, (mis || we) ? 0 : W + 1);
                chk("addr_stable", bad, 0);
            end else chk("fair_wait", {31'b0, lat <= 2 * W + 4}, 1);
            order.push_back(int'(p));
        end
        @(posedge clk); #1;
        if (solo) chk("wr_pulses", n_wr - wr0, (we && !mis) ? 1 : 0);
        drive(p, 0, we, op, ext, a, wd);
    endtask

    task automatic agent(input bit p, input int n);
        logic [31:0] rd;
        logic err;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            xact(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 DATA_BASE + 32'($urandom_range(0, 31)), $urandom, 0, rd, err);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic err;
        bit seen, got;
        int wr0, lat;
        for (int i = 0; i < 64; i++) begin mem[i] = '0; shadow[i] = '0; end
        rst = 1'b1;
        drive(0, 0, 0, MEM_WORD, 0, 0, 0);
        drive(1, 0, 0, MEM_WORD, 0, 0, 0);
        bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_op = MEM_WORD; bus0.cpu_ext = 0; bus0.cpu_addr = 0; bus0.cpu_wdata = 0;
        bus0.dbg_req = 0; bus0.dbg_we = 0; bus0.dbg_op = MEM_WORD; bus0.dbg_ext = 0; bus0.dbg_addr = 0; bus0.dbg_wdata = 0;
        #3;
        chk("rst_ctl", {25'b0, bus.mem_wr, bus.mem_rd, bus.mem_ext, bus.cpu_ready, bus.cpu_err, bus.dbg_ready, bus.dbg_err}, 0);
        chk("rst_op", {30'b0, bus.mem_op}, {30'b0, MEM_WORD});
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", bus.cpu_rdata | bus.dbg_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        xact(0, 1, MEM_WORD, 0, DATA_BASE + 32'h10, 32'hDEADBEEF, 1, rd, err);
        xact(0, 0, MEM_WORD, 0, DATA_BASE + 32'h10, 0, 1, rd, err);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);

        xact(1, 1, MEM_WORD, 0, DATA_BASE + 32'h20, 32'h80FF1234, 1, rd, err);
        xact(1, 0, MEM_BYTE, 1, DATA_BASE + 32'h23, 0, 1, rd, err);
        chk("lb", rd, 32'hFFFFFF80);
        xact(1, 0, MEM_BYTE, 0, DATA_BASE + 32'h21, 0, 1, rd, err);
        chk("lbu", rd, 32'h00000012);
        xact(1, 0, MEM_HALF, 1, DATA_BASE + 32'h22, 0, 1, rd, err);
        chk("lh", rd, 32'hFFFF80FF);
        chk("cpu_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);

        xact(0, 1, MEM_WORD, 0, DATA_BASE + 32'h22, 32'h11111111, 1, rd, err);
        chk("mis_sw_err", {31'b0, err}, 1);
        xact(0, 0, MEM_HALF, 0, DATA_BASE + 32'h21, 0, 1, rd, err);
        xact(0, 0, MEM_WORD, 0, DATA_BASE + 32'h20, 0, 1, rd, err);
        chk("mis_unchanged", rd, 32'h80FF1234);

        wr0 = n_wr;
        drive(0, 1, 1, MEM_WORD, 0, DATA_BASE + 32'h30, 32'h12345678);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", {28'b0, bus.mem_wr, bus.mem_rd, bus.cpu_ready, bus.dbg_ready}, 0);
        chk("rst_mid_addr", bus.mem_addr, 0);
        chk("rst_mid_op", {30'b0, bus.mem_op}, {30'b0, MEM_WORD});
        drive(0, 0, 0, MEM_WORD, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (W + 4) begin @(posedge clk); #1; seen |= bus.cpu_ready | bus.dbg_ready; end
        chk("rst_no_ready", {31'b0, seen}, 0);
        chk("rst_no_wr", n_wr - wr0, 0);

        order.delete();
        fork
            begin
                logic [31:0] r0; logic e0;
                xact(0, 0, MEM_WORD, 0, DATA_BASE + 32'h30, 0, 0, r0, e0);
                chk("rst_store_dropped", r0, 0);
                repeat (3) xact(0, 1, MEM_WORD, 0, DATA_BASE + 32'h34, $urandom, 0, r0, e0);
            end
            begin
                logic [31:0] r1; logic e1;
                repeat (4) xact(1, 0, MEM_BYTE, 1, DATA_BASE + 32'h23, 0, 0, r1, e1);
            end
        join
        chk("alt_count", order.size(), 8);
        for (int k = 0; k < order.size(); k++) chk($sformatf("alt%0d", k), order[k], k % 2);

        bus0.cpu_req = 1; bus0.cpu_we = 0; bus0.cpu_addr = DATA_BASE + 32'h40;
        got = 0; lat = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (bus0.cpu_ready) begin got = 1; lat = i; end
        end
        chk("w0_load_lat", got ? lat : -1, 1);
        chk("w0_load_rdata", bus0.cpu_rdata, (DATA_BASE + 32'h40) ^ W0_XOR);
        @(posedge clk); #1;
        wr0 = n_wr0;
        bus0.cpu_we = 1; bus0.cpu_wdata = 32'hCAFEF00D;
        got = 0; lat = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (bus0.cpu_ready) begin got = 1; lat = i; end
        end
        chk("w0_store_lat", got ? lat : -1, 1);
        chk("w0_store_rdata", bus0.cpu_rdata, 0);
        chk("w0_wr_pulses", n_wr0 - wr0, 1);
        @(posedge clk); #1;
        bus0.cpu_req = 0;

        fork
            agent(0, 30);
            agent(1, 30);
        join

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
